// File: rtl/ipbus_wb_txn_master.sv
// ipbus_wb_txn_master
//   Wishbone classic-cycle master driven by a single-outstanding transaction
//   stream. Accepts one request (op/addr/wdata), runs it on the bus, and
//   returns read data and a completion status. A per-access timeout aborts
//   accesses to a slave that never answers.
//
// Parameters
//   TIMEOUT_CYCLES : STB cycles allowed without ACK/ERR (1..65535)
//   CNT_W          : timeout counter width
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake
//   req_op, req_addr, req_wdata   : op 00 WRITE, 01 READ, 10 IDLE, 11 illegal
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata, rsp_status         : status 00 OK, 01 BUS_ERR, 10 TIMEOUT, 11 BAD_OP
//   wb_*                          : Wishbone classic master signals
//
// Optional: define IPBUS_WB_STATS_EN to add stats_clr and the
//   stat_txn / stat_err / stat_tmo response counters.

module ipbus_wb_txn_master #(
    parameter int TIMEOUT_CYCLES = 4000,
    parameter int CNT_W          = 16
) (
`ifdef IPBUS_WB_STATS_EN
    input  logic        stats_clr,
    output logic [31:0] stat_txn,
    output logic [31:0] stat_err,
    output logic [31:0] stat_tmo,
`endif
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_status,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_IDLE  = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_BAD_OP  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              cyc_d, stb_d, we_d;
    logic [31:0]       adr_d, dat_d, rdata_d;
    logic [1:0]        status_d;

    // Handshake outputs are pure state decodes, so they cannot disagree
    // with the FSM.
    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            wb_cyc_o   <= cyc_d;
            wb_stb_o   <= stb_d;
            wb_we_o    <= we_d;
            wb_adr_o   <= adr_d;
            wb_dat_o   <= dat_d;
            rsp_rdata  <= rdata_d;
            rsp_status <= status_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cyc_d    = wb_cyc_o;
        stb_d    = wb_stb_o;
        we_d     = wb_we_o;
        adr_d    = wb_adr_o;
        dat_d    = wb_dat_o;
        rdata_d  = rsp_rdata;
        status_d = rsp_status;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_WRITE, OP_READ: begin
                            state_d = S_BUS;
                            cnt_d   = '0;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            we_d    = (req_op == OP_WRITE);
                            adr_d   = req_addr;
                            dat_d   = (req_op == OP_WRITE) ? req_wdata : 32'h0;
                        end
                        OP_IDLE: begin
                            state_d  = S_RESP;
                            rdata_d  = 32'h0;
                            status_d = ST_OK;
                        end
                        default: begin
                            state_d  = S_RESP;
                            rdata_d  = 32'h0;
                            status_d = ST_BAD_OP;
                        end
                    endcase
                end
            end

            S_BUS: begin
                cnt_d = cnt + 1'b1;
                // Priority ERR > ACK > TIMEOUT; a reply on the last allowed
                // cycle still counts as a reply.
                if (wb_err_i || wb_ack_i || (cnt == CNT_LAST)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    rdata_d = 32'h0;
                    if (wb_err_i) begin
                        status_d = ST_BUS_ERR;
                    end else if (wb_ack_i) begin
                        status_d = ST_OK;
                        // WE is still valid here; it only drops on exit.
                        if (!wb_we_o) rdata_d = wb_dat_i;
                    end else begin
                        status_d = ST_TIMEOUT;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

`ifdef IPBUS_WB_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stat_txn <= '0;
            stat_err <= '0;
            stat_tmo <= '0;
        end else if (rsp_fire) begin
            stat_txn <= stat_txn + 32'd1;
            if (rsp_status == ST_BUS_ERR || rsp_status == ST_BAD_OP)
                stat_err <= stat_err + 32'd1;
            if (rsp_status == ST_TIMEOUT)
                stat_tmo <= stat_tmo + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ipbus_wb_txn_master.sv
// Directed bench for ipbus_wb_txn_master with TIMEOUT_CYCLES=16.
module tb_ipbus_wb_txn_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;
`ifdef IPBUS_WB_STATS_EN
    logic        stats_clr;
    logic [31:0] stat_txn, stat_err, stat_tmo;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ipbus_wb_txn_master #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
`ifdef IPBUS_WB_STATS_EN
        .stats_clr (stats_clr),
        .stat_txn  (stat_txn),
        .stat_err  (stat_err),
        .stat_tmo  (stat_tmo),
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_status (rsp_status),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i)
    );

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one accepting edge.
    task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    // Slave model: counts STB cycles; replies during STB cycle ack_at
    // (0 = never reply). Bounded at 40 cycles.
    task automatic run_bus(input int ack_at, input logic err, input logic [31:0] rd, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!wb_stb_o) break;
            n++;
            if (n == ack_at) begin
                wb_ack_i = 1'b1;
                wb_err_i = err;
                wb_dat_i = rd;
            end
            tick();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; req_op = 2'b10; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
`ifdef IPBUS_WB_STATS_EN
        stats_clr = 1'b0;
`endif
        tick(); tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_status", rsp_status, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        tick();

        // WRITE with two wait states
        send(2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
        chk("wr_req_ready", req_ready, 0);
        chk("wr_cyc", wb_cyc_o, 1);
        chk("wr_we", wb_we_o, 1);
        chk("wr_adr", wb_adr_o, 32'h0000_0010);
        chk("wr_dat", wb_dat_o, 32'hDEAD_BEEF);
        run_bus(3, 1'b0, 32'h5555_5555, n);
        chk("wr_stb_cycles", n, 3);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_status", rsp_status, 2'b00);
        chk("wr_rdata", rsp_rdata, 0);
        chk("wr_cyc_drop", wb_cyc_o, 0);
        chk("wr_we_drop", wb_we_o, 0);
        chk("wr_adr_hold", wb_adr_o, 32'h0000_0010);
        tick();
        chk("wr_done_valid", rsp_valid, 0);
        chk("wr_done_ready", req_ready, 1);

        // READ zero-wait, response held back for 10 cycles
        rsp_ready = 1'b0;
        send(2'b01, 32'h0000_0020, 32'hFFFF_0000);
        chk("rd_we", wb_we_o, 0);
        chk("rd_dat_o", wb_dat_o, 0);
        chk("rd_adr", wb_adr_o, 32'h0000_0020);
        run_bus(1, 1'b0, 32'h1234_5678, n);
        chk("rd_stb_cycles", n, 1);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rdata", rsp_rdata, 32'h1234_5678);
        chk("rd_status", rsp_status, 2'b00);
        req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h0000_0099;
        wb_dat_i = 32'hFFFF_FFFF; wb_ack_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_rdata", rsp_rdata, 32'h1234_5678);
            chk("hold_status", rsp_status, 2'b00);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_cyc", wb_cyc_o, 0);
        end
        req_valid = 1'b0; wb_ack_i = 1'b0; rsp_ready = 1'b1;
        tick();
        chk("hold_release", rsp_valid, 0);

        // Silent slave -> TIMEOUT after 16 STB cycles
        send(2'b01, 32'h0000_0030, 32'h0);
        run_bus(0, 1'b0, 32'h0, n);
        chk("tmo_stb_cycles", n, 16);
        chk("tmo_cyc", wb_cyc_o, 0);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_status", rsp_status, 2'b10);
        chk("tmo_rdata", rsp_rdata, 0);
        tick();

        // ACK on the 16th STB cycle beats the timeout
        send(2'b01, 32'h0000_0034, 32'h0);
        run_bus(16, 1'b0, 32'hCAFE_F00D, n);
        chk("late_ack_cycles", n, 16);
        chk("late_ack_status", rsp_status, 2'b00);
        chk("late_ack_rdata", rsp_rdata, 32'hCAFE_F00D);
        tick();

        // ERR together with ACK -> BUS_ERR
        send(2'b00, 32'h0000_0040, 32'h1111_2222);
        run_bus(1, 1'b1, 32'h7777_7777, n);
        chk("err_status", rsp_status, 2'b01);
        chk("err_rdata", rsp_rdata, 0);
        tick();

        // IDLE op: no bus cycle, OK
        send(2'b10, 32'h0000_0050, 32'h0);
        chk("idle_cyc", wb_cyc_o, 0);
        chk("idle_rsp_valid", rsp_valid, 1);
        chk("idle_status", rsp_status, 2'b00);
        tick();

        // Illegal op: no bus cycle, BAD_OP
        send(2'b11, 32'h0000_0060, 32'h0);
        chk("bad_cyc", wb_cyc_o, 0);
        chk("bad_rsp_valid", rsp_valid, 1);
        chk("bad_status", rsp_status, 2'b11);
        chk("bad_rdata", rsp_rdata, 0);
        tick();

        // Reset during S_BUS abandons the access
        send(2'b01, 32'h0000_0070, 32'h0);
        tick();
        chk("mid_cyc_before", wb_cyc_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_cyc", wb_cyc_o, 0);
        chk("mid_stb", wb_stb_o, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_req_ready", req_ready, 1);
        chk("mid_adr", wb_adr_o, 0);
        tick(); tick(); tick();
        chk("mid_no_rsp", rsp_valid, 0);
        chk("mid_no_cyc", wb_cyc_o, 0);

`ifdef IPBUS_WB_STATS_EN
        chk("st_rst_txn", stat_txn, 0);
        for (int i = 0; i < 3; i++) begin
            send(2'b10, 32'h0, 32'h0);
            tick();
        end
        send(2'b00, 32'h0000_0080, 32'h0);
        run_bus(1, 1'b1, 32'h0, n);
        tick();
        send(2'b01, 32'h0000_0084, 32'h0);
        run_bus(0, 1'b0, 32'h0, n);
        tick();
        chk("st_txn", stat_txn, 5);
        chk("st_err", stat_err, 1);
        chk("st_tmo", stat_tmo, 1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("st_clr_txn", stat_txn, 0);
        chk("st_clr_err", stat_err, 0);
        chk("st_clr_tmo", stat_tmo, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ipbus_wb_txn_master.md
Name: ipbus_wb_txn_master

Overview:
- Synthesizable Wishbone classic-cycle master. Consumes one transaction at a time (operation, 32-bit address, 32-bit data) from the IPbus-side transaction source over a valid/ready handshake.
- Executes the transaction on the Wishbone bus and returns read data plus a completion status over a second valid/ready handshake.
- Enforces a per-access bus timeout, so a silent slave never stalls the upstream transaction stream.

Parameters:
- TIMEOUT_CYCLES, 4000, clock cycles the STB may remain unacknowledged before the access is aborted; legal range 1..65535.
- CNT_W, 16, width of the internal timeout counter.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  transaction request present
- req_ready  out  1  block can accept a request
- req_op  in  2  00 WRITE, 01 READ, 10 IDLE, 11 illegal
- req_addr  in  32  transaction address
- req_wdata  in  32  write data (ignored unless WRITE)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  read data (0 for non-READ)
- rsp_status  out  2  00 OK, 01 BUS_ERR, 10 TIMEOUT, 11 BAD_OP
- wb_cyc_o  out  1  Wishbone CYC
- wb_stb_o  out  1  Wishbone STB
- wb_we_o  out  1  Wishbone WE
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_dat_i  in  32  Wishbone read data
- wb_ack_i  in  1  Wishbone ACK
- wb_err_i  in  1  Wishbone ERR

Behaviour:
- Reset values: req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_status=00; wb_cyc_o=0; wb_stb_o=0; wb_we_o=0; wb_adr_o=0; wb_dat_o=0; timeout counter=0; state=S_IDLE.
- FSM states: S_IDLE, S_BUS, S_RESP.
- S_IDLE:
  - req_ready=1.
  - On req_valid at edge T, capture op/addr/wdata and drop req_ready.
  - WRITE/READ: go to S_BUS. From T+1, wb_cyc_o=wb_stb_o=1, wb_adr_o=addr, wb_we_o=(op==WRITE), wb_dat_o=wdata (0 for READ).
  - IDLE op: no bus cycle. Go to S_RESP with status OK, rdata 0; rsp_valid from T+1.
  - op 11: no bus cycle. Go to S_RESP with status BAD_OP, rdata 0.
- S_BUS:
  - Hold all wb_* outputs stable; timeout counter increments once per cycle in S_BUS.
  - Edge with wb_err_i=1: status BUS_ERR, rdata 0.
  - Else edge with wb_ack_i=1: status OK; rdata=wb_dat_i if READ, else 0.
  - Else counter reaches TIMEOUT_CYCLES-1: status TIMEOUT, rdata 0.
  - Any exit: next cycle cyc/stb/we=0, counter=0, rsp_valid=1, state S_RESP.
  - ERR and ACK together: ERR wins. ACK/ERR on the final timeout cycle: ACK/ERR wins over TIMEOUT.
  - Timeout asserts rsp_valid exactly TIMEOUT_CYCLES+1 cycles after acceptance.
  - ACK/ERR are sampled only in S_BUS; ACK/ERR in any other state is ignored.
- S_RESP:
  - rsp_valid=1; rsp_rdata and rsp_status held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, req_ready=1 next cycle, state S_IDLE.
  - No new request is accepted while a response is pending.
- Latency:
  - Zero-wait slave (ACK in the first STB cycle): acceptance at T, STB at T+1, rsp_valid at T+2.
  - Minimum transaction period 3 cycles with rsp_ready tied high.
- Reset mid-operation: rst asserted in any state gives all reset values at the next edge. An in-flight bus cycle is abandoned (CYC drops) and any pending response is discarded.
- wb_adr_o and wb_dat_o keep their last values while idle; only CYC/STB/WE return to 0.

Optional Feature:
- Macro: IPBUS_WB_STATS_EN.
- Defined: adds input stats_clr (1) and outputs stat_txn (32), stat_err (32), stat_tmo (32).
  - Counters increment on each response handshake: stat_txn for every handshake, stat_err when status is BUS_ERR or BAD_OP, stat_tmo when status is TIMEOUT.
  - Counters wrap modulo 2^32; reset to 0 on rst or stats_clr.
  - stats_clr and an increment in the same cycle: clear wins.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- WRITE addr 0x0000_0010, data 0xDEAD_BEEF; slave ACKs after 2 wait cycles -> wb_we_o=1, adr/dat match, STB high 3 cycles, response OK, rdata 0.
- READ addr 0x0000_0020; slave ACKs immediately with 0x1234_5678 -> rsp_valid 2 cycles after acceptance, rdata 0x1234_5678, status OK.
- READ with TIMEOUT_CYCLES=16 and silent slave -> STB high exactly 16 cycles, CYC drops, status TIMEOUT, rdata 0. Repeat with ACK on the 16th cycle -> status OK.
- WRITE where slave asserts ERR and ACK together -> status BUS_ERR. Next: op IDLE -> no CYC, status OK. Then op 11 -> no CYC, status BAD_OP.
- Hold rsp_ready low 10 cycles after a READ response -> rsp fields stable, req_ready=0 throughout; issue rst during a later S_BUS -> CYC/STB low the next cycle, no response produced.
- With IPBUS_WB_STATS_EN: 3 OK, 1 BUS_ERR, 1 TIMEOUT -> stat_txn=5, stat_err=1, stat_tmo=1. stats_clr -> all 0 the next cycle.
